// File: rtl/apb_pkg.sv
// apb_pkg: shared types and default parameters for the APB decoder
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int DEF_PROT_W = 3;
  localparam int DEF_PSTRB_W = 4;
  localparam int NUM_SLV = 4;
  localparam logic [31:0] DEF_BASE0 = 32'h0000_0000;
  localparam logic [31:0] DEF_BASE1 = 32'h0001_0000;
  localparam logic [31:0] DEF_BASE2 = 32'h0002_0000;
  localparam logic [31:0] DEF_BASE3 = 32'h0003_0000;
  localparam logic [31:0] DEF_MASK = 32'hFFFF_0000;
endpackage

// File: rtl/apb_addr_dec.sv
// apb_addr_dec: base/mask address compare, lowest matching slave wins
module apb_addr_dec import apb_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter logic [AW-1:0] BASE0 = AW'(DEF_BASE0),
  parameter logic [AW-1:0] BASE1 = AW'(DEF_BASE1),
  parameter logic [AW-1:0] BASE2 = AW'(DEF_BASE2),
  parameter logic [AW-1:0] BASE3 = AW'(DEF_BASE3),
  parameter logic [AW-1:0] MASK0 = AW'(DEF_MASK),
  parameter logic [AW-1:0] MASK1 = AW'(DEF_MASK),
  parameter logic [AW-1:0] MASK2 = AW'(DEF_MASK),
  parameter logic [AW-1:0] MASK3 = AW'(DEF_MASK)
) (
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [1:0]    idx
);
  logic [NUM_SLV-1:0] hits;
  // compare every window, then pick the lowest-numbered match
  always_comb begin
    hits[0] = (addr & MASK0) == BASE0;
    hits[1] = (addr & MASK1) == BASE1;
    hits[2] = (addr & MASK2) == BASE2;
    hits[3] = (addr & MASK3) == BASE3;
    hit = |hits;
    idx = hits[0] ? 2'd0 : hits[1] ? 2'd1 : hits[2] ? 2'd2 : 2'd3;
  end
endmodule

// File: rtl/apb_decoder.sv
// apb_decoder: registered APB 1-to-4 decoder with unmapped-error and timeout watchdog
module apb_decoder import apb_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int PROT_W = DEF_PROT_W,
  parameter int PSTRB_W = DEF_PSTRB_W,
  parameter logic [AW-1:0] BASE0 = AW'(DEF_BASE0),
  parameter logic [AW-1:0] BASE1 = AW'(DEF_BASE1),
  parameter logic [AW-1:0] BASE2 = AW'(DEF_BASE2),
  parameter logic [AW-1:0] BASE3 = AW'(DEF_BASE3),
  parameter logic [AW-1:0] MASK0 = AW'(DEF_MASK),
  parameter logic [AW-1:0] MASK1 = AW'(DEF_MASK),
  parameter logic [AW-1:0] MASK2 = AW'(DEF_MASK),
  parameter logic [AW-1:0] MASK3 = AW'(DEF_MASK),
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                preset_n,
  input  logic                m_psel,
  input  logic                m_penable,
  input  logic                m_pwrite,
  input  logic [PROT_W-1:0]   m_pprot,
  input  logic [AW-1:0]       m_paddr,
  input  logic [DW-1:0]       m_pwdata,
  input  logic [PSTRB_W-1:0]  m_pstrb,
  output logic                m_pready,
  output logic                m_pslverr,
  output logic [DW-1:0]       m_prdata,
  output logic [3:0]          s_psel,
  output logic                s_penable,
  output logic                s_pwrite,
  output logic [PROT_W-1:0]   s_pprot,
  output logic [AW-1:0]       s_paddr,
  output logic [DW-1:0]       s_pwdata,
  output logic [PSTRB_W-1:0]  s_pstrb,
  input  logic [3:0]          s_pready,
  input  logic [3:0]          s_pslverr,
  input  logic [4*DW-1:0]     s_prdata,
  output logic                dec_err,
  output logic                timeout
);
  state_t      state;
  logic [1:0]  idx;
  logic [15:0] cnt;
  logic        hit;
  logic [1:0]  dec_idx;

  apb_addr_dec #(
    .AW(AW), .BASE0(BASE0), .BASE1(BASE1), .BASE2(BASE2), .BASE3(BASE3),
    .MASK0(MASK0), .MASK1(MASK1), .MASK2(MASK2), .MASK3(MASK3)
  ) u_dec (
    .addr(m_paddr),
    .hit (hit),
    .idx (dec_idx)
  );

  // transfer FSM: capture upstream request, run downstream SETUP/ACCESS, answer in RESP
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      s_psel <= '0;
      s_penable <= 1'b0;
      s_pwrite <= 1'b0;
      s_pprot <= '0;
      s_paddr <= '0;
      s_pwdata <= '0;
      s_pstrb <= '0;
      m_pready <= 1'b0;
      m_pslverr <= 1'b0;
      m_prdata <= '0;
      dec_err <= 1'b0;
      timeout <= 1'b0;
    end else begin
      m_pready <= 1'b0;
      dec_err <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: if (m_psel && !m_penable) begin
          s_paddr <= m_paddr;
          s_pwrite <= m_pwrite;
          s_pwdata <= m_pwdata;
          s_pstrb <= m_pstrb;
          s_pprot <= m_pprot;
          idx <= dec_idx;
          if (hit) begin
            state <= SETUP;
            s_psel <= 4'(1) << dec_idx;
          end else begin
            state <= RESP;
            m_pready <= 1'b1;
            m_pslverr <= 1'b1;
            m_prdata <= '0;
            dec_err <= 1'b1;
          end
        end
        SETUP: begin
          state <= ACCESS;
          s_penable <= 1'b1;
          cnt <= '0;
        end
        ACCESS: if (s_pready[idx]) begin
          state <= RESP;
          s_psel <= '0;
          s_penable <= 1'b0;
          m_pready <= 1'b1;
          m_pslverr <= s_pslverr[idx];
          m_prdata <= s_pwrite ? '0 : s_prdata[idx*DW +: DW];
        end else if (cnt == 16'(TIMEOUT - 1)) begin
          state <= RESP;
          s_psel <= '0;
          s_penable <= 1'b0;
          m_pready <= 1'b1;
          m_pslverr <= 1'b1;
          m_prdata <= '0;
          timeout <= 1'b1;
        end else
          cnt <= cnt + 16'd1;
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_decoder.sv
// tb_apb_decoder: table-driven check of the APB decoder plus reset corner case
module tb_apb_decoder;
  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic        m_psel = 1'b0, m_penable = 1'b0, m_pwrite = 1'b0;
  logic [2:0]  m_pprot = '0;
  logic [31:0] m_paddr = '0, m_pwdata = '0;
  logic [3:0]  m_pstrb = '0;
  logic        m_pready, m_pslverr;
  logic [31:0] m_prdata;
  logic [3:0]  s_psel;
  logic        s_penable, s_pwrite;
  logic [2:0]  s_pprot;
  logic [31:0] s_paddr, s_pwdata;
  logic [3:0]  s_pstrb;
  logic [3:0]  s_pready = '0, s_pslverr = '0;
  logic [127:0] s_prdata = '0;
  logic        dec_err, timeout;

  int checks = 0;
  int errors = 0;

  apb_decoder dut (
    .pclk(pclk), .preset_n(preset_n),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_pprot(m_pprot), .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_pprot(s_pprot), .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
    .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata),
    .dec_err(dec_err), .timeout(timeout)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic [31:0] rdata;
    logic        slverr;
    logic [3:0]  exp_psel;
    int          exp_cyc;
    int          exp_acc;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_dec;
    logic        exp_to;
    logic        chk_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_slaves(input vec_t v, input int acc);
    for (int k = 0; k < 4; k++) begin
      s_pready[k] = s_psel[k] ? (s_penable && acc == v.waits) : 1'b1;
      s_pslverr[k] = s_psel[k] ? v.slverr : 1'b1;
      s_prdata[k*32 +: 32] = s_psel[k] ? v.rdata : (32'hBAD0_0000 | 32'(k));
    end
  endtask

  task automatic run(input int n, input vec_t v);
    int cyc = 0, acc = 0;
    logic done = 0, psel_ok = 1, pay_ok = 1, psel_any = 0, dec_seen = 0, to_seen = 0;
    @(negedge pclk);
    m_psel = 1; m_penable = 0; m_paddr = v.addr; m_pwrite = v.write;
    m_pwdata = v.wdata; m_pstrb = v.strb; m_pprot = v.prot;
    drive_slaves(v, acc);
    while (!done && cyc < 60) begin
      @(negedge pclk);
      cyc++;
      m_penable = 1; m_paddr = ~v.addr; m_pwdata = ~v.wdata; m_pstrb = ~v.strb;
      if (s_psel != 0) begin
        psel_any = 1;
        if (s_psel !== v.exp_psel) psel_ok = 0;
        if (s_paddr !== v.addr || s_pwdata !== v.wdata || s_pstrb !== v.strb ||
            s_pwrite !== v.write || s_pprot !== v.prot) pay_ok = 0;
      end
      if (dec_err) dec_seen = 1;
      if (timeout) to_seen = 1;
      if (m_pready) done = 1;
      else begin
        drive_slaves(v, acc);
        if (s_penable) acc++;
      end
    end
    chk($sformatf("v%0d ready_cycle", n), 32'(cyc), 32'(v.exp_cyc));
    chk($sformatf("v%0d access_cycles", n), 32'(acc), 32'(v.exp_acc));
    chk($sformatf("v%0d pslverr", n), 32'(m_pslverr), 32'(v.exp_err));
    if (v.chk_rd) chk($sformatf("v%0d prdata", n), m_prdata, v.exp_rdata);
    chk($sformatf("v%0d psel_seen", n), 32'(psel_any), 32'(v.exp_psel != 0));
    chk($sformatf("v%0d psel_onehot", n), 32'(psel_ok), 32'd1);
    chk($sformatf("v%0d payload_stable", n), 32'(pay_ok), 32'd1);
    chk($sformatf("v%0d dec_err", n), 32'(dec_seen), 32'(v.exp_dec));
    chk($sformatf("v%0d timeout", n), 32'(to_seen), 32'(v.exp_to));
    @(negedge pclk);
    m_psel = 0; m_penable = 0;
    chk($sformatf("v%0d pready_one_cycle", n), 32'(m_pready), 32'd0);
    chk($sformatf("v%0d psel_idle", n), 32'(s_psel), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h0001_0004, 0, 32'h0, 4'hF, 3'd0, 0, 32'hDEAD_BEEF, 0, 4'b0010, 3, 1, 32'hDEAD_BEEF, 0, 0, 0, 1};
    vecs[1] = '{32'h0003_0010, 1, 32'h1234_5678, 4'hF, 3'd2, 3, 32'h0000_0055, 0, 4'b1000, 6, 4, 32'h0, 0, 0, 0, 1};
    vecs[2] = '{32'h0009_0000, 0, 32'h0, 4'hF, 3'd0, 0, 32'h0, 0, 4'b0000, 1, 0, 32'h0, 1, 1, 0, 0};
    vecs[3] = '{32'h0002_0100, 0, 32'h0, 4'hF, 3'd1, 1000, 32'h0000_0077, 0, 4'b0100, 18, 16, 32'h0, 1, 0, 1, 1};
    vecs[4] = '{32'h0000_0008, 0, 32'h0, 4'hF, 3'd0, 1, 32'hA5A5_0001, 1, 4'b0001, 4, 2, 32'hA5A5_0001, 1, 0, 0, 1};
    vecs[5] = '{32'h0002_FFFC, 1, 32'hCAFE_F00D, 4'h3, 3'd4, 0, 32'h0000_0099, 0, 4'b0100, 3, 1, 32'h0, 0, 0, 0, 1};
    vecs[6] = '{32'h0003_FFFF, 0, 32'h0, 4'hF, 3'd0, 2, 32'h0000_0001, 0, 4'b1000, 5, 3, 32'h0000_0001, 0, 0, 0, 1};
    vecs[7] = '{32'h0004_0000, 1, 32'h1, 4'h1, 3'd0, 0, 32'h0, 0, 4'b0000, 1, 0, 32'h0, 1, 1, 0, 0};
    vecs[8] = '{32'h0002_0000, 0, 32'h0, 4'hF, 3'd0, 15, 32'h1357_9BDF, 0, 4'b0100, 18, 16, 32'h1357_9BDF, 0, 0, 0, 1};
    #1;
    chk("reset m_pready", 32'(m_pready), 0);
    chk("reset s_psel", 32'(s_psel), 0);
    chk("reset m_prdata", m_prdata, 0);
    @(negedge pclk);
    @(negedge pclk);
    preset_n = 1;
    for (int i = 0; i < 9; i++) run(i, vecs[i]);
    // reset asserted in the middle of a slave-1 ACCESS phase
    @(negedge pclk);
    m_psel = 1; m_penable = 0; m_paddr = 32'h0001_0020; m_pwrite = 1;
    m_pwdata = 32'h0F0F_0F0F; m_pstrb = 4'hF; s_pready = 4'b0000;
    @(negedge pclk);
    m_penable = 1;
    @(negedge pclk);
    chk("pre_reset s_penable", 32'(s_penable), 1);
    chk("pre_reset s_psel", 32'(s_psel), 32'b0010);
    #2 preset_n = 0;
    #1;
    chk("async_reset s_psel", 32'(s_psel), 0);
    chk("async_reset s_penable", 32'(s_penable), 0);
    chk("async_reset s_paddr", s_paddr, 0);
    chk("async_reset s_pwdata", s_pwdata, 0);
    chk("async_reset m_pslverr", 32'(m_pslverr), 0);
    chk("async_reset m_pready", 32'(m_pready), 0);
    @(negedge pclk);
    m_psel = 0; m_penable = 0;
    @(negedge pclk);
    chk("held_reset m_pready", 32'(m_pready), 0);
    preset_n = 1;
    run(9, vecs[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
